// File: rtl/wide_to_narrow_coupler_pkg.sv
// Shared definitions for the wide-to-narrow memory coupler.
//   state_t : controller states
//   beats() : number of short beats needed to carry one long line
package coupler_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FINISH,
    RELAX
  } state_t;

  function automatic int beats(input int line_bytes, input int short_bytes);
    return (short_bytes > 0) ? (line_bytes / short_bytes) : 1;
  endfunction

endpackage

// File: rtl/wide_to_narrow_coupler_if.sv
// Simple memory request/response bus, BYTES wide.
//   Request : addr, data_i, data_en (byte enables), read_en, write_en
//   Response: data_o, hit (request completes this cycle), done
// Modports:
//   bus    - the memory side (receives requests, returns responses)
//   driver - the requesting side (issues requests, receives responses)
interface mem_if #(
  parameter int BYTES = 4
);
  logic [31:0]        addr;
  logic [8*BYTES-1:0] data_i;
  logic [BYTES-1:0]   data_en;
  logic               read_en;
  logic               write_en;
  logic [8*BYTES-1:0] data_o;
  logic               hit;
  logic               done;

  modport bus (
    input  addr, data_i, data_en, read_en, write_en,
    output data_o, hit, done
  );

  modport driver (
    output addr, data_i, data_en, read_en, write_en,
    input  data_o, hit, done
  );
endinterface

// File: rtl/wide_to_narrow_coupler.sv
// Splits one LINE_BYTES-wide memory request into a sequence of SHORT_BYTES-wide
// beats on a narrower downstream bus, gathers read data back into a line buffer
// and answers upstream with a one-cycle hit followed by a one-cycle done.
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous, active-high; aborts any transaction in flight
//   long_in_if   - upstream line-wide bus (mem_if.bus, LINE_BYTES)
//   short_out_if - downstream beat-wide bus (mem_if.driver, SHORT_BYTES)
module wide_to_narrow_coupler
  import coupler_pkg::*;
#(
  parameter int LINE_BYTES        = 64,
  parameter int SHORT_BYTES       = 4,
  parameter bit SKIP_EMPTY_WRITES = 1'b1
) (
  input  logic  clk,
  input  logic  reset,
  mem_if.bus    long_in_if,
  mem_if.driver short_out_if
);

  localparam int BEATS = beats(LINE_BYTES, SHORT_BYTES);
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW    = 8 * LINE_BYTES;
  localparam int SW    = 8 * SHORT_BYTES;

  if ((SHORT_BYTES < 1) || ((SHORT_BYTES & (SHORT_BYTES - 1)) != 0) ||
      (SHORT_BYTES > LINE_BYTES) || ((LINE_BYTES % SHORT_BYTES) != 0)) begin : g_bad_params
    $error("wide_to_narrow_coupler: SHORT_BYTES must be a power of two dividing LINE_BYTES");
  end

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       beat_idx, beat_nxt;
  logic [31:0]            addr_q;
  logic [LW-1:0]          data_q;
  logic [LINE_BYTES-1:0]  en_q;
  logic [LW-1:0]          rbuf_q;

  logic [BEATS-1:0]       live;
  logic [IDX_W-1:0]       cur;
  logic                   cur_valid;
  logic                   more_after;
  logic                   beat_done;

  // Beat selection: with skipping enabled a write only visits beats that carry
  // at least one enabled byte, so the search jumps straight to the next such
  // beat instead of spending a cycle on every empty one.
  always_comb begin
    live       = '1;
    cur        = beat_idx;
    cur_valid  = 1'b0;
    more_after = 1'b0;
    for (int b = 0; b < BEATS; b++) begin
      if (SKIP_EMPTY_WRITES && (state == WRITE))
        live[b] = |en_q[b*SHORT_BYTES +: SHORT_BYTES];
    end
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (live[b] && (b >= int'(beat_idx))) begin
        cur       = IDX_W'(b);
        cur_valid = 1'b1;
      end
    end
    for (int b = 0; b < BEATS; b++) begin
      if (live[b] && (b > int'(cur)))
        more_after = 1'b1;
    end
  end

  // Downstream request: everything derives from latched state, so it stays
  // stable for as long as the beat waits for hit.
  assign short_out_if.addr     = addr_q + 32'(SHORT_BYTES) * 32'(cur);
  assign short_out_if.data_i   = data_q[int'(cur)*SW +: SW];
  assign short_out_if.data_en  = en_q[int'(cur)*SHORT_BYTES +: SHORT_BYTES];
  assign short_out_if.read_en  = (state == READ);
  assign short_out_if.write_en = (state == WRITE) && cur_valid;

  assign beat_done = (short_out_if.read_en | short_out_if.write_en) & short_out_if.hit;

  assign long_in_if.hit    = (state == FINISH);
  assign long_in_if.done   = (state == RELAX);
  assign long_in_if.data_o = rbuf_q;

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_idx;
    case (state)
      IDLE: begin
        beat_nxt = '0;
        if (long_in_if.read_en)       state_nxt = READ;
        else if (long_in_if.write_en) state_nxt = WRITE;
      end
      READ, WRITE: begin
        if (!cur_valid) begin
          state_nxt = FINISH;
        end else if (beat_done) begin
          if (more_after) beat_nxt = cur + IDX_W'(1);
          else            state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = RELAX;
      RELAX:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      beat_idx <= '0;
    end else begin
      state    <= state_nxt;
      beat_idx <= beat_nxt;
    end
  end

  // Request capture and read-data gathering; data is not reset so an aborted
  // read simply leaves whatever beats already landed in the buffer.
  always_ff @(posedge clk) begin
    if ((state == IDLE) && (long_in_if.read_en || long_in_if.write_en)) begin
      addr_q <= long_in_if.addr;
      data_q <= long_in_if.data_i;
      en_q   <= long_in_if.data_en;
    end
    if ((state == READ) && beat_done)
      rbuf_q[int'(cur)*SW +: SW] <= short_out_if.data_o;
  end

endmodule

// File: tb/tb_wide_to_narrow_coupler.sv
module tb_wide_to_narrow_coupler;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: 16/4 skip on, instance 1: 16/4 skip off, instance 2: 64/8 skip on
  mem_if #(.BYTES(16)) la ();
  mem_if #(.BYTES(4))  sa ();
  mem_if #(.BYTES(16)) lb ();
  mem_if #(.BYTES(4))  sb ();
  mem_if #(.BYTES(64)) lc ();
  mem_if #(.BYTES(8))  sc ();

  wide_to_narrow_coupler #(.LINE_BYTES(16), .SHORT_BYTES(4), .SKIP_EMPTY_WRITES(1'b1)) u_a (
    .clk(clk), .reset(reset), .long_in_if(la), .short_out_if(sa));
  wide_to_narrow_coupler #(.LINE_BYTES(16), .SHORT_BYTES(4), .SKIP_EMPTY_WRITES(1'b0)) u_b (
    .clk(clk), .reset(reset), .long_in_if(lb), .short_out_if(sb));
  wide_to_narrow_coupler #(.LINE_BYTES(64), .SHORT_BYTES(8), .SKIP_EMPTY_WRITES(1'b1)) u_c (
    .clk(clk), .reset(reset), .long_in_if(lc), .short_out_if(sc));

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  en;
    bit          we;
  } sbeat_t;

  typedef struct {
    int           hit_cyc;
    bit           chk_data;
    logic [511:0] data;
  } lexp_t;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  en;
    int           waitc;
    int           hitc;
    logic [127:0] exp;
  } vec_t;

  sbeat_t       exp_s[3][$];
  lexp_t        exp_l[3][$];
  int           wait_cyc[3];
  int           done_due[3];
  int           done_cnt[3];
  logic [511:0] last_rd[3];
  bit           have_read[3];
  int           checks, errors;
  int           cnt_a, cnt_b, cnt_c;
  vec_t         vecs[9];

  function automatic logic [31:0] mem_a(input logic [31:0] a);
    return 32'hA0 + ((a - 32'h100) >> 2);
  endfunction

  function automatic logic [63:0] mem_c(input logic [31:0] a);
    return {a ^ 32'hDEADBEEF, a};
  endfunction

  // Downstream memory models: hit after wait_cyc idle cycles of a held request
  assign sa.hit    = (sa.read_en | sa.write_en) && (cnt_a >= wait_cyc[0]);
  assign sa.data_o = mem_a(sa.addr);
  assign sa.done   = sa.hit;
  assign sb.hit    = (sb.read_en | sb.write_en) && (cnt_b >= wait_cyc[1]);
  assign sb.data_o = mem_a(sb.addr);
  assign sb.done   = sb.hit;
  assign sc.hit    = (sc.read_en | sc.write_en) && (cnt_c >= wait_cyc[2]);
  assign sc.data_o = mem_c(sc.addr);
  assign sc.done   = sc.hit;

  always @(posedge clk) begin
    cnt_a <= ((sa.read_en | sa.write_en) && !sa.hit) ? cnt_a + 1 : 0;
    cnt_b <= ((sb.read_en | sb.write_en) && !sb.hit) ? cnt_b + 1 : 0;
    cnt_c <= ((sc.read_en | sc.write_en) && !sc.hit) ? cnt_c + 1 : 0;
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic short_mon(input int id, input logic rd, input logic wr, input logic hit,
                           input logic [31:0] addr, input logic [63:0] data, input logic [7:0] en);
    sbeat_t e;
    if (rd && wr) chk($sformatf("rd_and_wr%0d", id), 512'(rd & wr), 512'd0);
    if ((rd || wr) && hit) begin
      if (exp_s[id].size() == 0) begin
        chk($sformatf("beat_unexpected%0d", id), 512'(hit), 512'd0);
      end else begin
        e = exp_s[id].pop_front();
        chk($sformatf("beat_addr%0d", id), 512'(addr), 512'(e.addr));
        chk($sformatf("beat_is_write%0d", id), 512'(wr), 512'(e.we));
        if (e.we) begin
          chk($sformatf("beat_data%0d", id), 512'(data), 512'(e.data));
          chk($sformatf("beat_en%0d", id), 512'(en), 512'(e.en));
        end
      end
    end
  endtask

  task automatic long_mon(input int id, input logic hit, input logic done, input logic [511:0] data);
    lexp_t e;
    if (hit) begin
      if (exp_l[id].size() == 0) begin
        chk($sformatf("hit_unexpected%0d", id), 512'(hit), 512'd0);
      end else begin
        e = exp_l[id].pop_front();
        chk($sformatf("hit_cycle%0d", id), 512'(cyc), 512'(e.hit_cyc));
        if (e.chk_data) chk($sformatf("line_data%0d", id), data, e.data);
        done_due[id] = cyc + 1;
      end
    end
    if (done) begin
      chk($sformatf("done_cycle%0d", id), 512'(cyc), 512'(done_due[id]));
      done_due[id] = -1;
      done_cnt[id]++;
    end
  endtask

  always @(negedge clk) begin
    short_mon(0, sa.read_en, sa.write_en, sa.hit, sa.addr, 64'(sa.data_i), 8'(sa.data_en));
    short_mon(1, sb.read_en, sb.write_en, sb.hit, sb.addr, 64'(sb.data_i), 8'(sb.data_en));
    short_mon(2, sc.read_en, sc.write_en, sc.hit, sc.addr, sc.data_i, sc.data_en);
    long_mon(0, la.hit, la.done, 512'(la.data_o));
    long_mon(1, lb.hit, lb.done, 512'(lb.data_o));
    long_mon(2, lc.hit, lc.done, lc.data_o);
  end

  task automatic drive(input int id, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [511:0] data, input logic [63:0] en);
    case (id)
      0: begin
        la.addr = addr; la.data_i = data[127:0]; la.data_en = en[15:0];
        la.read_en = rd; la.write_en = wr;
      end
      1: begin
        lb.addr = addr; lb.data_i = data[127:0]; lb.data_en = en[15:0];
        lb.read_en = rd; lb.write_en = wr;
      end
      default: begin
        lc.addr = addr; lc.data_i = data; lc.data_en = en;
        lc.read_en = rd; lc.write_en = wr;
      end
    endcase
  endtask

  // Push the expected beats and line response, present the request for one
  // cycle, then scramble the upstream inputs and wait for done.
  task automatic issue(input int id, input bit wr, input logic [31:0] addr, input logic [511:0] data,
                       input logic [63:0] en, input int waitc, input int hitc, input logic [511:0] exp_data);
    int     nb, c0, d0;
    bit     skip;
    sbeat_t sx;
    lexp_t  lx;
    nb   = (id == 2) ? 8 : 4;
    skip = (id != 1);
    for (int i = 0; i < nb; i++) begin
      sx.addr = addr + 32'(nb * i);
      sx.data = '0;
      sx.en   = '0;
      sx.we   = wr;
      for (int k = 0; k < nb; k++) begin
        sx.data[8*k +: 8] = data[8*(nb*i + k) +: 8];
        sx.en[k]          = en[nb*i + k];
      end
      if (!wr || !skip || (sx.en != 8'd0)) exp_s[id].push_back(sx);
    end
    if (wr) begin
      lx.chk_data = have_read[id];
      lx.data     = last_rd[id];
    end else begin
      lx.chk_data   = 1'b1;
      lx.data       = exp_data;
      last_rd[id]   = exp_data;
      have_read[id] = 1'b1;
    end
    @(negedge clk);
    c0 = cyc;
    lx.hit_cyc = c0 + hitc;
    exp_l[id].push_back(lx);
    d0 = done_cnt[id];
    wait_cyc[id] = waitc;
    drive(id, !wr, wr, addr, data, en);
    @(negedge clk);
    drive(id, 1'b0, 1'b0, ~addr, ~data, ~en);
    for (int k = 0; k < 400 && done_cnt[id] == d0; k++) @(negedge clk);
    chk($sformatf("done_seen%0d", id), 512'(done_cnt[id] - d0), 512'd1);
    chk($sformatf("beats_left%0d", id), 512'(exp_s[id].size()), 512'd0);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    sbeat_t       ab;
    logic [511:0] cexp;
    int           c0, d0;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 3; i++) begin
      wait_cyc[i] = 0; done_due[i] = -1; done_cnt[i] = 0; have_read[i] = 1'b0; last_rd[i] = '0;
    end
    vecs[0] = '{wr:0, addr:32'h100, data:'0, en:'0, waitc:0, hitc:5,
                exp:128'h000000A3_000000A2_000000A1_000000A0};
    vecs[1] = '{wr:1, addr:32'h100, data:128'h44444444_33333333_22222222_11111111, en:16'h00F0,
                waitc:0, hitc:2, exp:'0};
    vecs[2] = '{wr:1, addr:32'h100, data:128'h55555555_66666666_77777777_88888888, en:16'h0000,
                waitc:0, hitc:2, exp:'0};
    vecs[3] = '{wr:0, addr:32'h200, data:'0, en:'0, waitc:2, hitc:13,
                exp:128'h000000E3_000000E2_000000E1_000000E0};
    vecs[4] = '{wr:1, addr:32'h400, data:128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, en:16'hF00F,
                waitc:1, hitc:5, exp:'0};
    vecs[5] = '{wr:1, addr:32'h500, data:128'h01234567_89ABCDEF_FEDCBA98_76543210, en:16'h0100,
                waitc:0, hitc:2, exp:'0};
    vecs[6] = '{wr:0, addr:32'h104, data:'0, en:'0, waitc:0, hitc:5,
                exp:128'h000000A4_000000A3_000000A2_000000A1};
    vecs[7] = '{wr:1, addr:32'h600, data:128'h0F0E0D0C_0B0A0908_07060504_03020100, en:16'hFFFF,
                waitc:0, hitc:5, exp:'0};
    vecs[8] = '{wr:0, addr:32'h100, data:'0, en:'0, waitc:1, hitc:9,
                exp:128'h000000A3_000000A2_000000A1_000000A0};

    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, '0, '0, '0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_long_hit", 512'(la.hit), 512'd0);
    chk("rst_long_done", 512'(la.done), 512'd0);
    chk("rst_short_rd", 512'(sa.read_en), 512'd0);
    chk("rst_short_wr", 512'(sa.write_en), 512'd0);
    chk("rst_c_hit", 512'(lc.hit), 512'd0);
    chk("rst_c_rd", 512'(sc.read_en), 512'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      issue(0, vecs[i].wr, vecs[i].addr, 512'(vecs[i].data), 64'(vecs[i].en),
            vecs[i].waitc, vecs[i].hitc, 512'(vecs[i].exp));

    // Reset while the third beat of a read is waiting for hit
    ab.data = '0; ab.en = '0; ab.we = 1'b0;
    ab.addr = 32'h300; exp_s[0].push_back(ab);
    ab.addr = 32'h304; exp_s[0].push_back(ab);
    @(negedge clk);
    c0 = cyc;
    wait_cyc[0] = 3;
    drive(0, 1'b1, 1'b0, 32'h300, '0, '0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'hFFFF_0000, '1, '1);
    d0 = done_cnt[0];
    repeat (9) @(negedge clk);
    chk("abort_cycle", 512'(cyc - c0), 512'd10);
    chk("abort_pending_rd", 512'(sa.read_en), 512'd1);
    chk("abort_pending_addr", 512'(sa.addr), 512'h308);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_rd_low", 512'(sa.read_en), 512'd0);
    chk("abort_hit_low", 512'(la.hit), 512'd0);
    repeat (6) @(negedge clk);
    chk("abort_no_done", 512'(done_cnt[0] - d0), 512'd0);
    chk("abort_beats_left", 512'(exp_s[0].size()), 512'd0);
    have_read[0] = 1'b0;
    issue(0, 1'b0, 32'h100, '0, '0, 0, 5, 512'(vecs[0].exp));

    // Skip disabled: every beat of a write goes out, empty ones with data_en=0
    issue(1, 1'b1, 32'h100, 512'(128'h44444444_33333333_22222222_11111111), 64'h00F0, 0, 5, '0);

    // 64/8 read whose beat addresses wrap through zero
    for (int i = 0; i < 8; i++) cexp[64*i +: 64] = mem_c(32'hFFFF_FFF0 + 32'(8 * i));
    issue(2, 1'b0, 32'hFFFF_FFF0, '0, '0, 0, 9, cexp);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wide_to_narrow_coupler.md
WIDE_TO_NARROW_COUPLER -- requirements
Module: wide_to_narrow_coupler

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 64: byte width of the long (upstream) interface.
REQ-002 SHALL have parameter SHORT_BYTES, default 4: byte width of the short (downstream) interface; legal values are powers of two with SHORT_BYTES <= LINE_BYTES.
REQ-003 SHALL have parameter SKIP_EMPTY_WRITES, default 1: when set, write beats whose byte enables are all zero are not issued downstream.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port long_in_if, mem_if.bus, LINE_BYTES wide: upstream request (addr, data_i, data_en, read_en, write_en) and response (data_o, hit, done).
REQ-007 SHALL have port short_out_if, mem_if.driver, SHORT_BYTES wide: downstream request (addr, data_i, data_en, read_en, write_en) and response (data_o, hit, done).

Function
REQ-008 SHALL use BEATS = LINE_BYTES/SHORT_BYTES; the beat index SHALL be $clog2(BEATS) bits wide, minimum 1.
REQ-009 SHALL implement states IDLE, READ, WRITE, FINISH, RELAX.
REQ-010 In IDLE with read_en=1, SHALL go to READ; read_en takes priority when read_en and write_en are both 1.
REQ-011 In IDLE with read_en=0 and write_en=1, SHALL go to WRITE.
REQ-012 On accepting a request, SHALL latch addr, data_i and data_en; upstream may change them afterwards without effect.
REQ-013 SHALL set beat i address = latched addr + SHORT_BYTES*i, computed as 32 bits modulo 2^32.
REQ-014 SHALL drive short data_i and data_en from latched byte slice [SHORT_BYTES*i +: SHORT_BYTES].
REQ-015 SHALL hold short read_en/write_en together with addr, data_i and data_en stable until short hit=1; a beat completes in the cycle in which short hit=1.
REQ-016 On read-beat completion, SHALL write short data_o into buffer slice i on the same clock edge.
REQ-017 When the last beat completes, SHALL go to FINISH; otherwise SHALL advance to the next beat to be issued.
REQ-018 With SKIP_EMPTY_WRITES=1, SHALL skip write beats whose data_en slice is all zero.
REQ-019 With SKIP_EMPTY_WRITES=1 and an all-zero write data_en, SHALL go from WRITE directly to FINISH and issue no short request.
REQ-020 SHALL assert long hit only in FINISH, for exactly 1 cycle; FINISH then goes to RELAX and RELAX goes to IDLE.
REQ-021 SHALL assert long done one cycle after long hit, for exactly 1 cycle.
REQ-022 SHALL drive long data_o from the buffer and hold it stable from FINISH until the next read completes its first beat.
REQ-023 SHALL ignore new requests in READ, WRITE, FINISH and RELAX.
REQ-024 With a zero-wait short side, a read SHALL be accepted at cycle 0, issue beats at cycles 1..BEATS, assert long hit at cycle BEATS+1 and long done at BEATS+2.
REQ-025 Short read_en=1 only in READ and short write_en=1 only in WRITE, never both; short data_i SHALL be don't-care outside WRITE.

Reset
REQ-026 reset=1 SHALL force state=IDLE, beat index=0, long hit=0, long done=0, short read_en=0, short write_en=0.
REQ-027 reset mid-transaction SHALL abort it without long hit or long done; buffer contents are not reset.

Structure
REQ-028 SHALL place the state enum and a beats(LINE_BYTES, SHORT_BYTES) constant function in shared package coupler_pkg.
REQ-029 SHALL be one module with no sub-modules; parameter legality SHALL be checked by elaboration-time assertions.

Verification
REQ-030 LINE_BYTES=16, SHORT_BYTES=4, zero-wait read of 0x100 returning 0xA0..0xA3 -> short addrs 0x100/0x104/0x108/0x10C, long data_o=0xA3A2A1A0 words MSW-first, hit cycle 5, done cycle 6.
REQ-031 Same config, write data_en=0x00F0 with skip on -> exactly one short write at addr 0x104 with data_en=0xF; with skip off -> four writes, others data_en=0.
REQ-032 Write with data_en=0 and skip on -> no short request; long hit at cycle 2.
REQ-033 Read with 2 wait cycles per beat, upstream addr changed after accept -> short addrs still derive from latched addr; hit at cycle 13.
REQ-034 reset asserted during beat 2 of a read -> short read_en low next cycle, no long hit/done; next read completes normally.
REQ-035 LINE_BYTES=64, SHORT_BYTES=8, read at 0xFFFFFFF0 -> 8 beats, addr wraps to 0x00000000 at beat 2.
